seg7_mux_driver_param: RTL

Parametrised multiplexed 7-segment display driver: accepts a binary value with a load strobe, converts it sequentially to BCD, and time-multiplexes the result over `DIGITS` common-anode/cathode digits at a configurable refresh rate. It adds leading-zero blanking, overflow indication and a busy/done handshake. It sits between the decoder datapath and the board display pins, succeeding the fixed 4-digit driver.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/bin_to_bcd_seq.sv | 114 +++++++++++
 rtl/seg7_mux_driver_param.sv | 89 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: segment
// patterns (active-high, bit0=a .. bit6=g), the conversion FSM states and
// small constant helpers.
package seg7_pkg;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_t;

    // BCD digit to active-high segment pattern; non-decimal codes go dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // 10^n, used at elaboration time to size the overflow limit.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (one double-dabble step per clock)
// with a committed display register and busy/done handshake.
module bin_to_bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  reloj,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      binario,
    input  logic                  cargar,
    output logic                  ocupado,
    output logic                  listo,
    output logic                  desborde,
    output logic [4*DIGITS-1:0]   bcd_disp
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int STEP_W = (BIN_W > 1) ? $clog2(BIN_W) + 1 : 1;
    localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

    conv_state_t        state_reg, state_next;
    logic [BIN_W-1:0]   bin_reg, bin_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next, bcd_adj;
    logic [STEP_W-1:0]  step_reg, step_next;
    logic               ovf_reg, ovf_next;
    logic [BCD_W-1:0]   disp_reg, disp_next;
    logic               desborde_reg, desborde_next;
    logic               listo_reg, listo_next;
    logic               ocupado_reg;

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end

    // State register.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath update; a load is taken only once ocupado has dropped.
    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        step_next     = step_reg;
        ovf_next      = ovf_reg;
        disp_next     = disp_reg;
        desborde_next = desborde_reg;
        listo_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cargar && !ocupado_reg) begin
                    state_next = CONV;
                    bin_next   = binario;
                    bcd_next   = '0;
                    step_next  = '0;
                    ovf_next   = 64'(binario) > LIMIT;
                end
            end
            CONV: begin
                bin_next  = bin_reg << 1;
                bcd_next  = {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
                step_next = step_reg + 1'b1;
                if (step_reg == STEP_W'(BIN_W - 1)) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                disp_next     = bcd_reg;
                desborde_next = ovf_reg;
                listo_next    = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and handshake registers; ocupado trails the state by one cycle.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg      <= '0;
            bcd_reg      <= '0;
            step_reg     <= '0;
            ovf_reg      <= 1'b0;
            disp_reg     <= '0;
            desborde_reg <= 1'b0;
            listo_reg    <= 1'b0;
            ocupado_reg  <= 1'b0;
        end else begin
            bin_reg      <= bin_next;
            bcd_reg      <= bcd_next;
            step_reg     <= step_next;
            ovf_reg      <= ovf_next;
            disp_reg     <= disp_next;
            desborde_reg <= desborde_next;
            listo_reg    <= listo_next;
            ocupado_reg  <= (state_reg != IDLE);
        end
    end

    assign ocupado  = ocupado_reg;
    assign listo    = listo_reg;
    assign desborde = desborde_reg;
    assign bcd_disp = disp_reg;

endmodule

// File: rtl/seg7_mux_driver_param.sv
// Multiplexed 7-segment driver: refresh prescaler, digit scan, leading-zero
// blanking, overflow dashes and polarity-adjusted output registers.
module seg7_mux_driver_param
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1,
    parameter bit LZ_BLANK    = 1
) (
    input  logic              reloj,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  binario,
    input  logic              cargar,
    output logic              ocupado,
    output logic              listo,
    output logic              desborde,
    output logic [DIGITS-1:0] anodo,
    output logic [6:0]        cSeg7
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};

    logic [4*DIGITS-1:0] bcd_disp;
    logic [PRE_W-1:0]    pre_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                pre_tc;
    logic [DIGITS:0]     upper_zero;
    logic [6:0]          seg_digit [DIGITS];
    logic [6:0]          seg_reg;
    logic [DIGITS-1:0]   anodo_reg;

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .reloj    (reloj),
        .rst_n    (rst_n),
        .binario  (binario),
        .cargar   (cargar),
        .ocupado  (ocupado),
        .listo    (listo),
        .desborde (desborde),
        .bcd_disp (bcd_disp)
    );

    assign pre_tc = (pre_reg == PRE_W'(REFRESH_DIV - 1));

    // Refresh prescaler and digit index; the index steps on terminal count.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else begin
            pre_reg <= pre_tc ? '0 : pre_reg + 1'b1;
            if (pre_tc) begin
                idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // upper_zero[i]: digit i and every digit above it are zero.
    assign upper_zero[DIGITS] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign upper_zero[gi] = upper_zero[gi+1] && (bcd_disp[4*gi +: 4] == 4'd0);
        assign seg_digit[gi]  = desborde ? SEG_DASH :
                                (LZ_BLANK && (gi > 0) && upper_zero[gi]) ? SEG_BLANK :
                                bcd_to_seg(bcd_disp[4*gi +: 4]);
    end

    // Output registers: select the current digit and apply pin polarity.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg   <= SEG_POL;
            anodo_reg <= AN_POL;
        end else begin
            seg_reg   <= seg_digit[idx_reg] ^ SEG_POL;
            anodo_reg <= (DIGITS'(1) << idx_reg) ^ AN_POL;
        end
    end

    assign cSeg7 = seg_reg;
    assign anodo = anodo_reg;

endmodule
